regfile_multi: RTL

Parametrised general-purpose register file: DEPTH entries of WIDTH bits, two read ports (A, B) and one write port, with write-first bypass. Adds an optional hardwired-zero entry 0. Adds a sequential clear-sweep engine that zeroes every entry, one per cycle, on request. Sits between the datapath ALU (feeds its A/B operand buses) and the writeback bus.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 57 +++++
 rtl/regfile_multi.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_multi register file.
// The optional registered-read build is selected with REGFILE_READ_REG_EN.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_e;

    // Wide enough for any practical WIDTH; users cast down with WIDTH'(ZERO_DATA).
    localparam logic [63:0] ZERO_DATA = '0;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: range/zero-entry masking, write-first bypass and, when
// REGFILE_READ_REG_EN is defined, a registered output stage.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned ADDR_W   = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [WIDTH-1:0]  byp_data,
    output logic [WIDTH-1:0]  data
);

    logic             in_range;
    logic             zero_sel;
    logic [WIDTH-1:0] rd_data;

    assign in_range = (32'(addr) < DEPTH);
    assign zero_sel = (ZERO_REG != 0) && (addr == '0);

    // byp_en already excludes out-of-range, zero-entry and sweep-time writes.
    always_comb begin
        rd_data = WIDTH'(ZERO_DATA);
        if (byp_en && (byp_addr == addr)) begin
            rd_data = byp_data;
        end else if (in_range && !zero_sel) begin
            rd_data = mem[addr];
        end
    end

`ifdef REGFILE_READ_REG_EN
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= WIDTH'(ZERO_DATA);
        end else begin
            data_q <= rd_data;
        end
    end

    assign data = data_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign data           = rd_data;
`endif

endmodule

// File: rtl/regfile_multi.sv
// Two-read/one-write register file with write-first bypass, optional hardwired
// zero entry and a one-entry-per-cycle clear sweep. Macro: REGFILE_READ_REG_EN.
module regfile_multi
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned ADDR_W   = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sa,
    input  logic [ADDR_W-1:0] sb,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  d,
    input  logic [ADDR_W-1:0] da,
    input  logic              w,
    input  logic              clr,
    output logic              busy,
    output logic              wr_drop
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_drop_q, wr_drop_d;
    logic              wr_ok;
    logic              last_idx;

    assign wr_ok = w && (state_q == ST_IDLE) && (32'(da) < DEPTH) &&
                   !((ZERO_REG != 0) && (da == '0));
    assign last_idx = (32'(idx_q) == DEPTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (last_idx) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SWEEP);
        wr_drop_d = (state_q == ST_SWEEP) && w;
    end

    assign wr_drop = wr_drop_q;

    // A write accepted on the clr cycle lands before the sweep starts overwriting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= WIDTH'(ZERO_DATA);
            end
        end else begin
            if (wr_ok) begin
                mem_q[da] <= d;
            end
            if (state_q == ST_SWEEP) begin
                mem_q[idx_q] <= WIDTH'(ZERO_DATA);
            end
        end
    end

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .addr     (sa),
        .mem      (mem_q),
        .byp_en   (wr_ok),
        .byp_addr (da),
        .byp_data (d),
        .data     (a)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .addr     (sb),
        .mem      (mem_q),
        .byp_en   (wr_ok),
        .byp_addr (da),
        .byp_data (d),
        .data     (b)
    );

endmodule
